// File: rtl/rgb_pkg.sv
// Shared types for the RGB hue sequencer: hue segment encoding and
// the segment-advance helper.
package rgb_pkg;

  typedef enum logic [2:0] {
    S_RG_UP = 3'd0,
    S_R_DN  = 3'd1,
    S_GB_UP = 3'd2,
    S_G_DN  = 3'd3,
    S_BR_UP = 3'd4,
    S_B_DN  = 3'd5
  } seg_t;

  localparam seg_t SEG_LAST = S_B_DN;

  function automatic seg_t seg_next(seg_t s);
    if (s == SEG_LAST)
      return S_RG_UP;
    return seg_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: the duty register reloads only at the period boundary,
// so a running period is never cut short or stretched.
module rgb_pwm_channel
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] duty,
  output logic                lit
);

  logic [PWM_BITS-1:0] duty_reg;
  logic                lit_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_reg <= '0;
      lit_reg  <= 1'b0;
    end else begin
      if (wrap)
        duty_reg <= duty;
      lit_reg <= (pwm_cnt < duty_reg);
    end
  end

  assign lit = lit_reg;

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Colour-wheel controller: walks the hue circle in six linear segments and
// drives three glitch-free PWM LED channels.
module rgb_hue_sequencer
  import rgb_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP_CLKS  = 7812,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] seg,
  output logic       cycle_done
);

  localparam int STEP_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CLKS - 1);

  seg_t                seg_reg;
  logic [PWM_BITS-1:0] level_reg;
  logic [STEP_W-1:0]   step_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                cycle_done_reg;

  logic                tick;
  logic                pwm_wrap;
  logic [PWM_BITS-1:0] inv_level;
  logic [PWM_BITS-1:0] duty_tgt [3];
  logic [2:0]          lit;

  assign tick      = en && (step_cnt_reg == STEP_LAST);
  assign pwm_wrap  = (pwm_cnt_reg == MAX);
  assign inv_level = MAX - level_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_reg        <= S_RG_UP;
      level_reg      <= '0;
      step_cnt_reg   <= '0;
      pwm_cnt_reg    <= '0;
      cycle_done_reg <= 1'b0;
    end else begin
      pwm_cnt_reg    <= pwm_cnt_reg + 1'b1;
      cycle_done_reg <= 1'b0;
      if (tick) begin
        step_cnt_reg <= '0;
        if (level_reg == MAX) begin
          level_reg      <= '0;
          seg_reg        <= seg_next(seg_reg);
          cycle_done_reg <= (seg_reg == SEG_LAST);
        end else begin
          level_reg <= level_reg + 1'b1;
        end
      end else if (en) begin
        step_cnt_reg <= step_cnt_reg + 1'b1;
      end
    end
  end

  // Index 0/1/2 = red/green/blue; each segment ramps exactly one channel.
  always_comb begin
    duty_tgt[0] = '0;
    duty_tgt[1] = '0;
    duty_tgt[2] = '0;
    case (seg_reg)
      S_RG_UP: begin duty_tgt[0] = MAX;       duty_tgt[1] = level_reg; end
      S_R_DN:  begin duty_tgt[0] = inv_level; duty_tgt[1] = MAX;       end
      S_GB_UP: begin duty_tgt[1] = MAX;       duty_tgt[2] = level_reg; end
      S_G_DN:  begin duty_tgt[1] = inv_level; duty_tgt[2] = MAX;       end
      S_BR_UP: begin duty_tgt[0] = level_reg; duty_tgt[2] = MAX;       end
      S_B_DN:  begin duty_tgt[0] = MAX;       duty_tgt[2] = inv_level; end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
        .clk     (clk),
        .reset   (reset),
        .pwm_cnt (pwm_cnt_reg),
        .wrap    (pwm_wrap),
        .duty    (duty_tgt[gi]),
        .lit     (lit[gi])
      );
    end
  endgenerate

  assign RGB_R      = (ACTIVE_LOW != 0) ? ~lit[0] : lit[0];
  assign RGB_G      = (ACTIVE_LOW != 0) ? ~lit[1] : lit[1];
  assign RGB_B      = (ACTIVE_LOW != 0) ? ~lit[2] : lit[2];
  assign seg        = seg_reg;
  assign cycle_done = cycle_done_reg;

endmodule
